// File: rtl/ups_adc_pkg.sv
// ups_adc_pkg: shared types and XADC constants for the UPS ADC sampler.
package ups_adc_pkg;

  localparam int unsigned DRP_ADDR_W  = 7;
  localparam logic [4:0]  VAUX_BASE   = 5'h10;
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_TIMEOUT = 0;
  localparam int unsigned ERR_OVERRUN = 1;
  localparam int unsigned ERR_DROP    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  // True when chn lies in [base, base+num); 6-bit math so base+num may reach 32.
  function automatic logic in_window(input logic [4:0] chn, input logic [4:0] base,
                                     input logic [4:0] num);
    logic [5:0] lo;
    logic [5:0] hi;
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, num};
    return ({1'b0, chn} >= lo) && ({1'b0, chn} < hi);
  endfunction

endpackage

// File: rtl/ups_adc_avg.sv
// ups_adc_avg: per-channel accumulator/counter bank. On strobe the sample is
// added to the indexed channel; when that channel's count wraps, done is high
// in the same cycle with the truncated mean, and the channel restarts at zero.
module ups_adc_avg
  import ups_adc_pkg::*;
#(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned IDX_W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] sample,
  input  logic              strobe,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((32'd1 << AVG_LOG2) - 32'd1);

  logic [ACC_W-1:0] acc_q [DEPTH];
  logic [ACC_W-1:0] acc_d [DEPTH];
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic [ACC_W-1:0] sum_s;
  logic             last_s;

  assign sum_s  = acc_q[idx] + ACC_W'(sample);
  assign last_s = (cnt_q[idx] == CNT_LAST);
  assign result = DATA_W'(sum_s >> AVG_LOG2);
  assign done   = strobe && last_s;

  // Next-state of the bank: accumulate, or emit and restart on the last sample.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (strobe) begin
      if (last_s) begin
        acc_d[idx] = {ACC_W{1'b0}};
        cnt_d[idx] = {CNT_W{1'b0}};
      end else begin
        acc_d[idx] = sum_s;
        cnt_d[idx] = cnt_q[idx] + CNT_W'(1'b1);
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Bank storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        acc_q[i] <= {ACC_W{1'b0}};
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ups_adc_sampler.sv
// ups_adc_sampler: XADC DRP read sequencer for a contiguous channel window with
// a valid/ready result register and sticky error flags.
// Optional feature macro UPS_ADC_AVG_EN: average 2^AVG_LOG2 conversions per
// channel (ups_adc_avg); when undefined every conversion is a result.
module ups_adc_sampler
  import ups_adc_pkg::*;
#(
  parameter int unsigned DATA_W   = 12,
  parameter logic [4:0]  CH_BASE  = VAUX_BASE,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  eoc,
  input  logic [4:0]            channel,
  output logic                  den,
  output logic [DRP_ADDR_W-1:0] daddr,
  input  logic [15:0]           do_in,
  input  logic                  drdy,
  output logic [DATA_W-1:0]     data,
  output logic [4:0]            ch,
  output logic                  valid,
  input  logic                  ready,
  output logic [ERR_W-1:0]      err,
  input  logic                  err_clr
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                state_q,  state_d;
  logic                  den_q,    den_d;
  logic [DRP_ADDR_W-1:0] daddr_q,  daddr_d;
  logic [4:0]            chan_q,   chan_d;
  logic [TMR_W-1:0]      timer_q,  timer_d;
  logic [DATA_W-1:0]     sample_q, sample_d;
  logic [DATA_W-1:0]     data_q,   data_d;
  logic [4:0]            ch_q,     ch_d;
  logic                  valid_q,  valid_d;
  logic [ERR_W-1:0]      err_q,    err_d;

  logic                  timeout_s;
  logic                  drop_s;
  logic                  overrun_s;
  logic [ERR_W-1:0]      err_new_s;
  logic                  res_done_s;
  logic [DATA_W-1:0]     res_s;
  logic                  res_strobe_s;
  logic                  do_in_unused_s;

  // Low DRP data bits below the result field are intentionally dropped.
  assign do_in_unused_s = ^do_in;

`ifdef UPS_ADC_AVG_EN
  logic [IDX_W-1:0] idx_s;
  assign idx_s = IDX_W'(chan_q - CH_BASE);

  ups_adc_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2),
    .IDX_W    (IDX_W)
  ) u_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .idx    (idx_s),
    .sample (sample_q),
    .strobe (state_q == ST_ACC),
    .result (res_s),
    .done   (res_done_s)
  );
`else
  localparam int unsigned avg_log2_unused = AVG_LOG2;
  localparam int unsigned idx_w_unused    = IDX_W;
  assign res_s      = sample_q;
  assign res_done_s = 1'b1;
`endif

  assign res_strobe_s = (state_q == ST_ACC) && res_done_s;
  assign overrun_s    = eoc && (state_q != ST_IDLE);

  // Next-state: read sequencing, output register handshake and error flags.
  always_comb begin
    state_d   = state_q;
    den_d     = 1'b0;
    daddr_d   = daddr_q;
    chan_d    = chan_q;
    timer_d   = timer_q;
    sample_d  = sample_q;
    data_d    = data_q;
    ch_d      = ch_q;
    valid_d   = valid_q;
    timeout_s = 1'b0;
    drop_s    = 1'b0;
    err_new_s = {ERR_W{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (eoc && in_window(channel, CH_BASE, 5'(NUM_CH))) begin
          den_d   = 1'b1;
          daddr_d = {2'b00, channel};
          chan_d  = channel;
          timer_d = {TMR_W{1'b0}};
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (drdy) begin
          sample_d = do_in[15 -: DATA_W];
          state_d  = ST_ACC;
        end else if (timer_q == TMR_LAST) begin
          timeout_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1'b1);
        end
      end
      ST_ACC: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (res_strobe_s) begin
      if (valid_q && !ready) begin
        drop_s = 1'b1;
      end else begin
        data_d  = res_s;
        ch_d    = chan_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    err_new_s[ERR_TIMEOUT] = timeout_s;
    err_new_s[ERR_OVERRUN] = overrun_s;
    err_new_s[ERR_DROP]    = drop_s;
    // A new error in the clear cycle still sets its flag.
    err_d = (err_clr ? {ERR_W{1'b0}} : err_q) | err_new_s;
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      den_q    <= 1'b0;
      daddr_q  <= {DRP_ADDR_W{1'b0}};
      chan_q   <= 5'd0;
      timer_q  <= {TMR_W{1'b0}};
      sample_q <= {DATA_W{1'b0}};
      data_q   <= {DATA_W{1'b0}};
      ch_q     <= 5'd0;
      valid_q  <= 1'b0;
      err_q    <= {ERR_W{1'b0}};
    end else begin
      state_q  <= state_d;
      den_q    <= den_d;
      daddr_q  <= daddr_d;
      chan_q   <= chan_d;
      timer_q  <= timer_d;
      sample_q <= sample_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign den   = den_q;
  assign daddr = daddr_q;
  assign data  = data_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ups_adc_sampler.sv
// tb_ups_adc_sampler: directed bench for ups_adc_sampler; expectations adapt
// to whether UPS_ADC_AVG_EN is defined (results need 2^2 reads per channel).
module tb_ups_adc_sampler;

`ifdef UPS_ADC_AVG_EN
  localparam int N_RD = 4;
`else
  localparam int N_RD = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        eoc;
  logic [4:0]  channel;
  logic        den;
  logic [6:0]  daddr;
  logic [15:0] do_in;
  logic        drdy;
  logic [11:0] data;
  logic [4:0]  ch;
  logic        valid;
  logic        ready;
  logic [2:0]  err;
  logic        err_clr;

  int n_assert;
  int n_fail;

  ups_adc_sampler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .eoc     (eoc),
    .channel (channel),
    .den     (den),
    .daddr   (daddr),
    .do_in   (do_in),
    .drdy    (drdy),
    .data    (data),
    .ch      (ch),
    .valid   (valid),
    .ready   (ready),
    .err     (err),
    .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // One DRP read: eoc, den check, dly WAIT cycles, drdy, then the ACC cycle.
  task automatic do_read(input logic [4:0] c, input logic [15:0] d, input int dly,
                         input bit rdy_acc);
    logic v0;
    eoc = 1'b1;
    channel = c;
    step();
    chk("den_pulse", den, 1);
    chk("daddr", daddr, {2'b00, c});
    eoc = 1'b0;
    step();
    chk("den_drop", den, 0);
    repeat (dly) step();
    v0 = valid;
    drdy = 1'b1;
    do_in = d;
    step();
    drdy = 1'b0;
    chk("valid_not_early", valid, v0);
    if (rdy_acc) ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic read_result(input logic [4:0] c, input logic [15:0] d, input bit rdy_last);
    for (int i = 0; i < N_RD - 1; i++) do_read(c, d, 2, 1'b0);
    do_read(c, d, 3, rdy_last);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    eoc      = 1'b0;
    channel  = 5'd0;
    do_in    = 16'h0000;
    drdy     = 1'b0;
    ready    = 1'b0;
    err_clr  = 1'b0;
    step();
    step();
    chk("rst_den", den, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_data", data, 0);
    chk("rst_ch", ch, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // Basic conversion on channel 0x10.
    read_result(5'h10, 16'hABC0, 1'b0);
    chk("single_valid", valid, 1);
    chk("single_data", data, 12'hABC);
    chk("single_ch", ch, 5'h10);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("handshake_clear", valid, 0);

    // Out-of-window channels are ignored silently.
    eoc = 1'b1;
    channel = 5'h12;
    step();
    chk("win_above_den", den, 0);
    channel = 5'h0F;
    step();
    chk("win_below_den", den, 0);
    eoc = 1'b0;
    step();
    chk("win_err", err, 0);

`ifdef UPS_ADC_AVG_EN
    // Interleaved channels average independently: (100+101+102+105)>>2 = 102.
    do_read(5'h11, 16'h1000, 2, 1'b0);
    do_read(5'h10, 16'h7FF0, 2, 1'b0);
    do_read(5'h11, 16'h1010, 2, 1'b0);
    do_read(5'h10, 16'h7FF0, 2, 1'b0);
    do_read(5'h11, 16'h1020, 2, 1'b0);
    chk("avg_partial_valid", valid, 0);
    do_read(5'h11, 16'h1050, 2, 1'b0);
    chk("avg_valid", valid, 1);
    chk("avg_data", data, 12'h102);
    chk("avg_ch", ch, 5'h11);
`else
    do_read(5'h11, 16'h1234, 2, 1'b0);
    chk("ch11_valid", valid, 1);
    chk("ch11_data", data, 12'h123);
    chk("ch11_ch", ch, 5'h11);
`endif
    ready = 1'b1;
    step();
    ready = 1'b0;
    reset_dut();

    // Backpressure: drop while held, then load on the handshake cycle.
    read_result(5'h10, 16'h1110, 1'b0);
    chk("bp_first_valid", valid, 1);
    chk("bp_first_data", data, 12'h111);
    read_result(5'h11, 16'h2220, 1'b0);
    chk("bp_drop_err", err, 3'b100);
    chk("bp_held_data", data, 12'h111);
    chk("bp_held_ch", ch, 5'h10);
    chk("bp_held_valid", valid, 1);
    read_result(5'h11, 16'h3330, 1'b1);
    chk("hs_load_valid", valid, 1);
    chk("hs_load_data", data, 12'h333);
    chk("hs_load_ch", ch, 5'h11);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", err, 0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("bp_release", valid, 0);

    // Timeout: 64 WAIT cycles with no drdy.
    eoc = 1'b1;
    channel = 5'h10;
    step();
    chk("to_den", den, 1);
    eoc = 1'b0;
    repeat (63) step();
    chk("to_not_yet", err, 3'b000);
    step();
    chk("to_flag", err, 3'b001);
    drdy = 1'b1;
    do_in = 16'hFFF0;
    step();
    drdy = 1'b0;
    step();
    chk("to_late_drdy", valid, 0);
    read_result(5'h10, 16'h5550, 1'b0);
    chk("after_to_valid", valid, 1);
    chk("after_to_data", data, 12'h555);

    // Overrun during WAIT, coinciding with err_clr: overrun wins, others clear.
    eoc = 1'b1;
    channel = 5'h10;
    step();
    eoc = 1'b0;
    step();
    eoc = 1'b1;
    channel = 5'h11;
    err_clr = 1'b1;
    step();
    eoc = 1'b0;
    err_clr = 1'b0;
    chk("ovr_no_den", den, 0);
    chk("ovr_err", err, 3'b010);

    // Reset while a read is outstanding.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_den", den, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_data", data, 0);
    step();
    rst_n = 1'b1;
    drdy = 1'b1;
    do_in = 16'hEEE0;
    step();
    drdy = 1'b0;
    step();
    step();
    chk("post_rst_drdy", valid, 0);
    read_result(5'h11, 16'h6780, 1'b0);
    chk("post_rst_valid", valid, 1);
    chk("post_rst_data", data, 12'h678);
    chk("post_rst_ch", ch, 5'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
